serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
// - Bit-serial adder: adds two WIDTH-bit operands plus carry-in, one bit per clock, LSB first.
// - Built around one instance of full_adder (ports a, b, cin, sum, carry).
// - A carry flip-flop closes the loop from carry back to cin.
// - Sits directly upstream of full_adder: sequences its operand bits and collects its sum/carry.
// - Used as the area-minimal adder option next to the combinational adders.
// PARAMETERS
// - WIDTH  default 8  operand/result width in bits; legal range 2..32.
// PORTS
// - clk    in   1      rising-edge clock
// - rst_n  in   1      asynchronous active-low reset
// - start  in   1      request; sampled on clk rising edge, accepted only in IDLE
// - a      in   WIDTH  operand A; captured when start is accepted
// - b      in   WIDTH  operand B; captured when start is accepted
// - cin    in   1      carry-in; captured when start is accepted
// - busy   out  1      high while an addition is in progress
// - done   out  1      one-cycle pulse: result valid
// - sum    out  WIDTH  result; held stable from done until the next accepted start
// - cout   out  1      carry-out of the MSB; held like sum
// BEHAVIOUR
// - Reset (rst_n=0, asynchronous):
//   - State -> IDLE; busy=0, done=0, sum=0, cout=0.
//   - Shift registers, carry flop and bit counter all cleared.
// - FSM states: IDLE, SHIFT.
//   - IDLE & start=1 at edge E0:
//     - Load sh_a<=a, sh_b<=b, carry<=cin, cnt<=0.
//     - -> SHIFT; busy=1 from E0.
//   - SHIFT, each edge E1..E_WIDTH:
//     - full_adder inputs: sh_a[0], sh_b[0], carry.
//     - Shift sh_a/sh_b right by 1.
//     - carry <= fa.carry.
//     - Shift fa.sum into the MSB of the result shift register.
//     - cnt <= cnt+1.
//   - At E_WIDTH (cnt==WIDTH-1):
//     - -> IDLE; busy=0.
//     - sum <= completed result; cout <= fa.carry.
//     - done=1 for exactly the cycle E_WIDTH..E_WIDTH+1.
// - Latency: done is high exactly WIDTH cycles after the accepting edge.
//   - Throughput: one add per WIDTH+1 cycles at most.
// - start while busy=1: ignored. No queuing; operands are not re-sampled.
// - start high at E_WIDTH+1 (state is IDLE, done falling): accepted. Back-to-back issue allowed.
// - start held high continuously: a new add is accepted at every IDLE edge.
// - sum/cout: changed only at E_WIDTH of a completed add.
//   - Not disturbed by accept or by the shifting phase.
//   - Previous result stays visible while busy=1.
// - Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). Unsigned; no overflow flag.
// - Counter width: $clog2(WIDTH); it wraps only via the reload on accept.
// - Reset mid-operation:
//   - Abort immediately; all outputs take their reset values.
//   - No done pulse for the aborted add.
// - a, b, cin: don't-care except at the accepting edge.
// TESTING
// - WIDTH=8. Reset, then start with a=8'h0F, b=8'h01, cin=0.
//   -> busy for 8 cycles; done at cycle 8; sum=8'h10, cout=0.
// - a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1 (full carry ripple through every bit).
// - a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
//   - a=8'h00, b=8'h00, cin=1 -> sum=8'h01, cout=0.
// - Start 8'h12+8'h34. Pulse start with a=8'hAA at cycle 3.
//   -> ignored; sum=8'h46, exactly one done pulse.
// - Start, then drop rst_n at cycle 4.
//   -> busy/done/sum/cout=0 immediately; no done; next add of 8'h05+8'h03 gives 8'h08.
// - Hold start=1 with new operands each IDLE edge.
//   -> done pulses every 9 cycles; each sum matches a+b+cin.
//   - Random sweep of 200 adds vs. reference model.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder cell, carry flop closes the loop, LSB first.
// Latency: done pulses WIDTH cycles after the accepting edge; one add per WIDTH+1 cycles.
// Backpressure: none; start is only accepted in IDLE and ignored while busy.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sh_a_q, sh_a_d;
    logic [WIDTH-1:0]   sh_b_q, sh_b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               done_q, done_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               fa_sum, fa_carry;
    logic [WIDTH-1:0]   res_shift;

    full_adder u_fa (
        .a     (sh_a_q[0]),
        .b     (sh_b_q[0]),
        .cin   (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // New sum bit enters at the MSB, so after WIDTH shifts bit 0 lands at the LSB.
    assign res_shift = {fa_sum, res_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sh_a_d  = a;
                    sh_b_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sh_a_d  = sh_a_q >> 1;
                sh_b_d  = sh_b_q >> 1;
                carry_d = fa_carry;
                res_d   = res_shift;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    sum_d   = res_shift;
                    cout_d  = fa_carry;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed and table-driven checks for serial_adder at WIDTH=8.
module tb_serial_adder;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic       cin;
    logic       busy, done, cout;
    logic [7:0] sum;

    int checks;
    int failures;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic       vc;
        logic [7:0] es;
        logic       ec;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issues one add, scrambles operands after accept, waits (bounded) for done.
    task automatic run_add(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                           output int lat, output logic busy_ok, output logic pulse_ok);
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        busy_ok = busy;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                if (busy) busy_ok = 1'b0;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        @(posedge clk); #1;
        pulse_ok = !done;
    endtask

    vec_t vecs[8];
    int lat;
    logic bok, pok;

    initial begin
        checks = 0; failures = 0;
        vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1};
        vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_sum",  32'(sum),  32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_add(vecs[i].va, vecs[i].vb, vecs[i].vc, lat, bok, pok);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
            chk($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].es));
            chk($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].ec));
            chk($sformatf("vec%0d_busy", i), 32'(bok), 32'd1);
            chk($sformatf("vec%0d_pulse", i), 32'(pok), 32'd1);
        end

        // start pulsed while busy must be ignored
        begin
            int ndone;
            int dcyc;
            logic [7:0] dsum;
            logic       prev_ok;
            ndone = 0; dcyc = -1; dsum = '0; prev_ok = 1'b1;
            @(negedge clk);
            a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            for (int k = 1; k <= 14; k++) begin
                if (k == 3) begin
                    @(negedge clk);
                    a = 8'hAA; b = 8'h01; start = 1'b1;
                end
                @(posedge clk); #1;
                start = 1'b0;
                if (k < 8 && sum !== 8'h80) prev_ok = 1'b0;
                if (done) begin
                    ndone++; dcyc = k; dsum = sum;
                end
            end
            chk("busy_ignore_ndone", 32'(ndone), 32'd1);
            chk("busy_ignore_cycle", 32'(dcyc), 32'd8);
            chk("busy_ignore_sum", 32'(dsum), 32'h46);
            chk("prev_result_held", 32'(prev_ok), 32'd1);
        end

        // reset in the middle of an add
        begin
            int ndone;
            ndone = 0;
            @(negedge clk);
            a = 8'h21; b = 8'h43; cin = 1'b1; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            chk("midrst_busy", 32'(busy), 32'd0);
            chk("midrst_done", 32'(done), 32'd0);
            chk("midrst_sum",  32'(sum),  32'd0);
            chk("midrst_cout", 32'(cout), 32'd0);
            @(negedge clk); rst_n = 1'b1;
            for (int k = 0; k < 10; k++) begin
                @(posedge clk); #1;
                if (done) ndone++;
            end
            chk("midrst_no_done", 32'(ndone), 32'd0);
            run_add(8'h05, 8'h03, 1'b0, lat, bok, pok);
            chk("post_rst_lat", 32'(lat), 32'd8);
            chk("post_rst_sum", 32'(sum), 32'h08);
            chk("post_rst_cout", 32'(cout), 32'd0);
        end

        // start held high: back-to-back adds every WIDTH+1 cycles
        begin
            logic [8:0] expq[$];
            logic [8:0] e;
            logic [7:0] ops[7][2];
            logic       prev_busy;
            int idx, last_done, ndone;
            ops = '{'{8'h01, 8'h02}, '{8'hF0, 8'h10}, '{8'h3C, 8'hC3}, '{8'h99, 8'h77},
                    '{8'h00, 8'hFF}, '{8'h40, 8'h40}, '{8'h0A, 8'h0B}};
            idx = 0; last_done = -1; ndone = 0; prev_busy = 1'b0;
            @(negedge clk);
            a = ops[0][0]; b = ops[0][1]; cin = 1'b1; start = 1'b1;
            for (int cyc = 0; cyc <= 60; cyc++) begin
                @(posedge clk); #1;
                if (busy && !prev_busy) begin
                    expq.push_back(9'(a) + 9'(b) + 9'(cin));
                    idx++;
                    a = ops[idx % 7][0]; b = ops[idx % 7][1]; cin = ~cin;
                end
                if (done) begin
                    e = (expq.size() > 0) ? expq.pop_front() : 9'h1FF;
                    chk($sformatf("b2b_result%0d", ndone), 32'({cout, sum}), 32'(e));
                    if (last_done >= 0)
                        chk($sformatf("b2b_interval%0d", ndone), 32'(cyc - last_done), 32'd9);
                    last_done = cyc;
                    ndone++;
                end
                prev_busy = busy;
            end
            start = 1'b0;
            chk("b2b_ndone", 32'(ndone), 32'd6);
            repeat (12) @(posedge clk);
        end

        // random sweep against the arithmetic model
        begin
            logic [7:0] ra, rb;
            logic       rc;
            int bad;
            bad = 0;
            for (int i = 0; i < 200; i++) begin
                ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
                run_add(ra, rb, rc, lat, bok, pok);
                if ({cout, sum} !== 9'(ra) + 9'(rb) + 9'(rc) || lat != 8 || !bok || !pok) begin
                    bad++;
                    if (bad <= 5)
                        $display("FAIL sweep%0d: %0h+%0h+%0h got %0h lat %0d", i, ra, rb, rc,
                                 {cout, sum}, lat);
                end
            end
            chk("sweep_errors", 32'(bad), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
